// File: rtl/cpmg_scan_sequencer.sv
// cpmg_scan_sequencer
// Scan-level controller for the CPMG pulse generator. Latches a scan
// configuration on start, then for each scan: holds the generator (and its
// DDS) in reset while presenting the start delay, releases it, counts
// refocusing pulses from gen_high falls, opens the ADC acquisition gate
// for each echo, keeps the last echo window open for ECHO_WIN cycles,
// then parks the generator in reset for the repetition time.
//
// Ports
//   clk, rst          125 MHz clock, synchronous active-low reset
//   i_start, i_abort  one-cycle requests (start honoured only in IDLE)
//   i_cfg_scans       scans per run (0 = start ignored)
//   i_cfg_echoes      refocusing pulses per scan
//   i_cfg_delay       generator start delay, forwarded on o_gen_delay
//   i_cfg_tr          recovery cycles between scans (0 treated as 1)
//   i_gen_high        generator output is at its high level
//   o_gen_rst_n       generator reset, 0 = held in reset
//   o_gen_delay       generator delay register, stable during ARM/RUN
//   o_acq_gate        echo acquisition window
//   o_scan_idx        current scan (0-based)
//   o_echo_idx        refocusing pulses completed in this scan
//   o_busy/o_done     not idle / one-cycle normal-completion pulse
//   o_error           sticky watchdog flag
module cpmg_scan_sequencer #(
  parameter int unsigned RST_HOLD  = 4,
  parameter int unsigned ECHO_WIN  = 156000,
  parameter int unsigned WD_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [15:0] i_cfg_scans,
  input  logic [15:0] i_cfg_echoes,
  input  logic [15:0] i_cfg_delay,
  input  logic [31:0] i_cfg_tr,
  input  logic        i_gen_high,
  output logic        o_gen_rst_n,
  output logic [15:0] o_gen_delay,
  output logic        o_acq_gate,
  output logic [15:0] o_scan_idx,
  output logic [15:0] o_echo_idx,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam logic [31:0] RST_LAST = 32'(RST_HOLD - 1);
  localparam logic [31:0] FIN_LAST = 32'(ECHO_WIN - 1);
  localparam logic [31:0] WD_LAST  = 32'(WD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RUN, S_FINAL, S_RECOVER
  } state_t;

  state_t      r_state;
  logic [15:0] r_scans;
  logic [15:0] r_echoes;
  logic [31:0] r_tr;
  logic [31:0] r_cnt;        // ARM hold / FINAL window / RECOVER timer
  logic [31:0] r_wd;         // cycles in RUN since the last gen_high edge
  logic        r_gen_high_q;
  logic        r_exc_done;   // excitation pulse has ended this scan
  logic        r_gen_rst_n;
  logic [15:0] r_gen_delay;
  logic        r_acq_gate;
  logic [15:0] r_scan_idx;
  logic [15:0] r_echo_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic        w_fall;
  logic        w_rise;
  logic [15:0] w_echo_nxt;
  logic [31:0] w_tr_last;

  assign w_fall     = r_gen_high_q & ~i_gen_high;
  assign w_rise     = ~r_gen_high_q & i_gen_high;
  assign w_echo_nxt = r_echo_idx + 16'd1;
  // A zero repetition time still spends one cycle in RECOVER.
  assign w_tr_last  = (r_tr == 32'd0) ? 32'd0 : r_tr - 32'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_scans      <= '0;
      r_echoes     <= '0;
      r_tr         <= '0;
      r_cnt        <= '0;
      r_wd         <= '0;
      r_gen_high_q <= 1'b0;
      r_exc_done   <= 1'b0;
      r_gen_rst_n  <= 1'b0;
      r_gen_delay  <= '0;
      r_acq_gate   <= 1'b0;
      r_scan_idx   <= '0;
      r_echo_idx   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Edge history only meaningful while the generator runs; cleared
      // elsewhere so a stale high can never fake a fall on RUN entry.
      r_gen_high_q <= (r_state == S_RUN) ? i_gen_high : 1'b0;

      if (i_abort) begin
        r_state     <= S_IDLE;
        r_gen_rst_n <= 1'b0;
        r_acq_gate  <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_gen_rst_n <= 1'b0;
            r_acq_gate  <= 1'b0;
            // The cycle carrying done is not a valid start slot.
            if (i_start && !r_done && i_cfg_scans != 16'd0) begin
              r_scans     <= i_cfg_scans;
              r_echoes    <= i_cfg_echoes;
              r_tr        <= i_cfg_tr;
              r_gen_delay <= i_cfg_delay;
              r_scan_idx  <= '0;
              r_echo_idx  <= '0;
              r_error     <= 1'b0;
              r_cnt       <= '0;
              r_busy      <= 1'b1;
              r_state     <= S_ARM;
            end
          end

          S_ARM: begin
            if (r_cnt == RST_LAST) begin
              r_state     <= S_RUN;
              r_gen_rst_n <= 1'b1;
              r_wd        <= '0;
              r_exc_done  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end

          S_RUN: begin
            if (w_fall) begin
              r_wd <= '0;
              if (!r_exc_done) begin
                r_exc_done <= 1'b1;
                if (r_echoes == 16'd0) begin
                  r_state     <= S_RECOVER;
                  r_gen_rst_n <= 1'b0;
                  r_cnt       <= '0;
                end
              end else begin
                r_echo_idx <= w_echo_nxt;
                r_acq_gate <= 1'b1;
                if (w_echo_nxt == r_echoes) begin
                  r_state <= S_FINAL;
                  r_cnt   <= '0;
                end
              end
            end else if (w_rise) begin
              r_wd       <= '0;
              r_acq_gate <= 1'b0;
            end else if (r_wd == WD_LAST) begin
              r_error     <= 1'b1;
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_gen_rst_n <= 1'b0;
              r_acq_gate  <= 1'b0;
            end else begin
              r_wd <= r_wd + 32'd1;
            end
          end

          S_FINAL: begin
            // Generator stays released so the last echo is not disturbed.
            if (r_cnt == FIN_LAST) begin
              r_state     <= S_RECOVER;
              r_gen_rst_n <= 1'b0;
              r_acq_gate  <= 1'b0;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end

          S_RECOVER: begin
            if (r_cnt == w_tr_last) begin
              r_cnt <= '0;
              if (r_scan_idx == r_scans - 16'd1) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_scan_idx <= r_scan_idx + 16'd1;
                r_echo_idx <= '0;
                r_state    <= S_ARM;
              end
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end

          default: begin
            r_state     <= S_IDLE;
            r_gen_rst_n <= 1'b0;
            r_acq_gate  <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_gen_rst_n = r_gen_rst_n;
  assign o_gen_delay = r_gen_delay;
  assign o_acq_gate  = r_acq_gate;
  assign o_scan_idx  = r_scan_idx;
  assign o_echo_idx  = r_echo_idx;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule

// File: tb/tb_cpmg_scan_sequencer.sv
// Directed bench for cpmg_scan_sequencer with a behavioural CPMG generator
// (delay, TAU high, TAU_LOW low, then TWO_TAU high / TWO_TAU_LOW low pulses).
module tb_cpmg_scan_sequencer;

  localparam int TAU = 4, TAU_LOW = 10, TWO_TAU = 8, TWO_TAU_LOW = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [15:0] cfg_scans = '0, cfg_echoes = '0, cfg_delay = '0;
  logic [31:0] cfg_tr = '0;
  logic        gen_high;
  logic        gen_rst_n, acq_gate, busy, done, error;
  logic [15:0] gen_delay, scan_idx, echo_idx;

  int checks = 0, errors = 0;

  cpmg_scan_sequencer #(.RST_HOLD(4), .ECHO_WIN(15), .WD_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .i_cfg_scans(cfg_scans), .i_cfg_echoes(cfg_echoes),
    .i_cfg_delay(cfg_delay), .i_cfg_tr(cfg_tr), .i_gen_high(gen_high),
    .o_gen_rst_n(gen_rst_n), .o_gen_delay(gen_delay), .o_acq_gate(acq_gate),
    .o_scan_idx(scan_idx), .o_echo_idx(echo_idx), .o_busy(busy),
    .o_done(done), .o_error(error)
  );

  always #4 clk = ~clk;

  // ---------------- generator model ----------------
  int   g_cnt = 0, g_ph = 0;
  logic g_hold = 1'b0;
  initial gen_high = 1'b0;

  function automatic int g_len(input int ph, input logic [15:0] d);
    case (ph)
      0: return (d == 16'd0) ? 1 : int'(d);
      1: return TAU;
      2: return TAU_LOW;
      3: return TWO_TAU;
      default: return TWO_TAU_LOW;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!gen_rst_n || g_hold) begin
      g_ph <= 0; g_cnt <= 0; gen_high <= 1'b0;
    end else if (g_cnt >= g_len(g_ph, gen_delay) - 1) begin
      g_cnt    <= 0;
      g_ph     <= (g_ph == 4) ? 3 : g_ph + 1;
      gen_high <= (g_ph == 0 || g_ph == 2 || g_ph == 4);
    end else begin
      g_cnt <= g_cnt + 1;
    end
  end

  // ---------------- observation monitor ----------------
  int   win_q[$], scan_q[$], rstlow_q[$];
  int   hi_cnt = 0, done_cnt = 0, tail_low = -1, acq_run = 0, low_run = 0;
  logic prev_hi = 1'b0, mon_clr = 1'b0;

  initial forever begin
    @(negedge clk);
    if (mon_clr) begin
      win_q.delete(); scan_q.delete(); rstlow_q.delete();
      hi_cnt = 0; done_cnt = 0; tail_low = -1; acq_run = 0; low_run = 0;
    end else begin
      if (acq_gate) acq_run++;
      else if (acq_run != 0) begin win_q.push_back(acq_run); acq_run = 0; end
      if (gen_high && !prev_hi) hi_cnt++;
      if (done) begin done_cnt++; tail_low = low_run; end
      if (busy && !gen_rst_n) low_run++;
      else if (gen_rst_n && low_run != 0) begin
        rstlow_q.push_back(low_run); scan_q.push_back(int'(scan_idx)); low_run = 0;
      end else if (!busy) low_run = 0;
    end
    prev_hi = gen_high;
  end

  // ---------------- helpers ----------------
  task automatic clear_mon();
    mon_clr = 1'b1; @(negedge clk); #1; mon_clr = 1'b0;
  endtask

  task automatic start_scan(input logic [15:0] s, input logic [15:0] e,
                            input logic [15:0] d, input logic [31:0] tr);
    cfg_scans = s; cfg_echoes = e; cfg_delay = d; cfg_tr = tr;
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin errors++; $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, n); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; repeat (3) @(negedge clk);
    checks += 8;
    if (gen_rst_n !== 1'b0) begin errors++; $display("FAIL reset gen_rst_n: got %b want 0", gen_rst_n); end
    if (gen_delay !== 16'd0) begin errors++; $display("FAIL reset gen_delay: got %0d want 0", gen_delay); end
    if (acq_gate !== 1'b0) begin errors++; $display("FAIL reset acq_gate: got %b want 0", acq_gate); end
    if (scan_idx !== 16'd0) begin errors++; $display("FAIL reset scan_idx: got %0d want 0", scan_idx); end
    if (echo_idx !== 16'd0) begin errors++; $display("FAIL reset echo_idx: got %0d want 0", echo_idx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    if (error !== 1'b0) begin errors++; $display("FAIL reset error: got %b want 0", error); end
    rst = 1'b1; @(negedge clk);
  endtask

  task automatic test_single();
    clear_mon();
    start_scan(1, 2, 3, 10);
    checks += 3;
    if (busy !== 1'b1) begin errors++; $display("FAIL single busy@T+1: got %b want 1", busy); end
    if (gen_delay !== 16'd3) begin errors++; $display("FAIL single gen_delay: got %0d want 3", gen_delay); end
    if (gen_rst_n !== 1'b0) begin errors++; $display("FAIL single gen_rst_n@T+1: got %b want 0", gen_rst_n); end
    wait_done(2000);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single busy@done: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    checks += 6;
    if (win_q.size() != 2 || win_q[0] != 20 || win_q[1] != 15) begin errors++; $display("FAIL single windows: got %p want '{20,15}", win_q); end
    if (rstlow_q.size() != 1 || rstlow_q[0] != 4) begin errors++; $display("FAIL single rst_hold: got %p want '{4}", rstlow_q); end
    if (echo_idx !== 16'd2) begin errors++; $display("FAIL single echo_idx: got %0d want 2", echo_idx); end
    if (done_cnt != 1) begin errors++; $display("FAIL single done_cnt: got %0d want 1", done_cnt); end
    if (hi_cnt != 3) begin errors++; $display("FAIL single high_periods: got %0d want 3", hi_cnt); end
    if (tail_low != 10) begin errors++; $display("FAIL single recover_len: got %0d want 10", tail_low); end
  endtask

  task automatic test_multi();
    clear_mon();
    start_scan(3, 1, 2, 5);
    wait_done(5000);
    repeat (2) @(negedge clk);
    checks += 6;
    if (scan_q.size() != 3 || scan_q[0] != 0 || scan_q[1] != 1 || scan_q[2] != 2) begin errors++; $display("FAIL multi scan_idx: got %p want '{0,1,2}", scan_q); end
    if (rstlow_q.size() != 3 || rstlow_q[0] != 4 || rstlow_q[1] != 9 || rstlow_q[2] != 9) begin errors++; $display("FAIL multi rst_low: got %p want '{4,9,9}", rstlow_q); end
    if (done_cnt != 1) begin errors++; $display("FAIL multi done_cnt: got %0d want 1", done_cnt); end
    if (hi_cnt != 6) begin errors++; $display("FAIL multi high_periods: got %0d want 6", hi_cnt); end
    if (win_q.size() != 3 || win_q[0] != 15 || win_q[1] != 15 || win_q[2] != 15) begin errors++; $display("FAIL multi windows: got %p want '{15,15,15}", win_q); end
    if (scan_idx !== 16'd2) begin errors++; $display("FAIL multi final scan_idx: got %0d want 2", scan_idx); end
  endtask

  task automatic test_zero_echo();
    clear_mon();
    start_scan(1, 0, 3, 6);
    wait_done(2000);
    repeat (2) @(negedge clk);
    checks += 4;
    if (win_q.size() != 0) begin errors++; $display("FAIL zero_echo windows: got %p want none", win_q); end
    if (hi_cnt != 1) begin errors++; $display("FAIL zero_echo high_periods: got %0d want 1", hi_cnt); end
    if (tail_low != 6) begin errors++; $display("FAIL zero_echo recover_len: got %0d want 6", tail_low); end
    if (echo_idx !== 16'd0) begin errors++; $display("FAIL zero_echo echo_idx: got %0d want 0", echo_idx); end
  endtask

  task automatic test_abort();
    int n = 0;
    clear_mon();
    start_scan(1, 2, 3, 10);
    while (echo_idx !== 16'd2 && n < 500) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    checks++;
    if (acq_gate !== 1'b1) begin errors++; $display("FAIL abort in_final acq_gate: got %b want 1", acq_gate); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b want 0", busy); end
    if (gen_rst_n !== 1'b0) begin errors++; $display("FAIL abort gen_rst_n: got %b want 0", gen_rst_n); end
    if (acq_gate !== 1'b0) begin errors++; $display("FAIL abort acq_gate: got %b want 0", acq_gate); end
    if (echo_idx !== 16'd2) begin errors++; $display("FAIL abort echo_idx hold: got %0d want 2", echo_idx); end
    clear_mon();
    repeat (30) @(negedge clk);
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort no_done: got %0d want 0", done_cnt); end
    start_scan(1, 1, 2, 4);
    checks++;
    if (echo_idx !== 16'd0) begin errors++; $display("FAIL abort restart echo_idx: got %0d want 0", echo_idx); end
    wait_done(2000);
    repeat (2) @(negedge clk);
    checks += 2;
    if (win_q.size() != 1 || win_q[0] != 15) begin errors++; $display("FAIL abort restart windows: got %p want '{15}", win_q); end
    if (done_cnt != 1) begin errors++; $display("FAIL abort restart done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_watchdog();
    int n = 0;
    clear_mon();
    g_hold = 1'b1;
    start_scan(1, 2, 3, 10);
    while (gen_rst_n !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (63) @(negedge clk);
    checks += 2;
    if (error !== 1'b0) begin errors++; $display("FAIL wd early error: got %b want 0", error); end
    if (busy !== 1'b1) begin errors++; $display("FAIL wd early busy: got %b want 1", busy); end
    @(negedge clk);
    checks += 3;
    if (error !== 1'b1) begin errors++; $display("FAIL wd error: got %b want 1", error); end
    if (busy !== 1'b0) begin errors++; $display("FAIL wd busy: got %b want 0", busy); end
    if (gen_rst_n !== 1'b0) begin errors++; $display("FAIL wd gen_rst_n: got %b want 0", gen_rst_n); end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL wd no_done: got %0d want 0", done_cnt); end
    g_hold = 1'b0;
    start_scan(1, 1, 2, 4);
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL wd clear on start: got %b want 0", error); end
    wait_done(2000);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    start_scan(1, 1, 2, 4);
    wait_done(2000);
    // start presented in the done cycle must be rejected
    cfg_scans = 16'd1; start = 1'b1; @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b start_in_done_cycle busy: got %b want 0", busy); end
    start_scan(1, 1, 2, 4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b next_start busy: got %b want 1", busy); end
    wait_done(2000);
    @(negedge clk);
  endtask

  task automatic test_cfg_ignore();
    clear_mon();
    start_scan(0, 1, 2, 4);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL cfg zero_scans busy: got %b want 0", busy); end
    start_scan(1, 1, 2, 4);
    repeat (2) @(negedge clk);
    start_scan(2, 3, 7, 100);
    checks += 2;
    if (gen_delay !== 16'd2) begin errors++; $display("FAIL cfg gen_delay stable: got %0d want 2", gen_delay); end
    if (busy !== 1'b1) begin errors++; $display("FAIL cfg busy during run: got %b want 1", busy); end
    wait_done(2000);
    repeat (2) @(negedge clk);
    checks += 4;
    if (win_q.size() != 1 || win_q[0] != 15) begin errors++; $display("FAIL cfg windows: got %p want '{15}", win_q); end
    if (hi_cnt != 2) begin errors++; $display("FAIL cfg high_periods: got %0d want 2", hi_cnt); end
    if (done_cnt != 1) begin errors++; $display("FAIL cfg done_cnt: got %0d want 1", done_cnt); end
    if (tail_low != 4) begin errors++; $display("FAIL cfg recover_len: got %0d want 4", tail_low); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_zero_echo();
    test_abort();
    test_watchdog();
    test_back_to_back();
    test_cfg_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpmg_scan_sequencer.md
# cpmg_scan_sequencer

Scan-level controller for the CPMG pulse generator. It latches a scan configuration, then runs num_scans acquisitions. For each scan it arms the generator: it holds the generator's active-low reset (which also satisfies the DDS compiler's resetn minimum) and presents the start delay. It counts refocusing pulses from the generator's high/low indication, gates the ADC acquisition window for every echo, stops the train cleanly after num_echoes, and waits a repetition time before the next scan.

## Interface
- RST_HOLD, 4: cycles gen_rst_n is held low in ARM; must be ≥2.
- ECHO_WIN, 156000: cycles the final echo window stays open after the last refocusing pulse falls; must be < generator low period so no further pulse starts.
- WD_CYCLES, 1048576: watchdog; maximum cycles in RUN without any gen_high edge.
- clk  in  1  125 MHz clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  one-cycle request; honoured in any state.
- cfg_scans  in  16  number of scans; latched on accepted start.
- cfg_echoes  in  16  refocusing pulses per scan; latched.
- cfg_delay  in  16  generator start delay; latched.
- cfg_tr  in  32  recovery cycles between scans; latched.
- gen_high  in  1  1 while generator data is HIGH_VALUE.
- gen_rst_n  out  1  drives the generator rst; 0 = generator and DDS held in reset.
- gen_delay  out  16  drives the generator delay_reg; stable throughout ARM and RUN.
- acq_gate  out  1  echo acquisition window.
- scan_idx  out  16  current scan, 0-based.
- echo_idx  out  16  refocusing pulses completed in the current scan.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse on normal completion.
- error  out  1  sticky watchdog flag; cleared by an accepted start or reset.

## Operation
- States: IDLE, ARM, RUN, FINAL, RECOVER.
- IDLE: gen_rst_n=0, acq_gate=0. If start=1 and the start-time cfg_scans≠0, latch all cfg_* and go to ARM with scan_idx=0 and error=0. If cfg_scans=0, ignore start.
- ARM: gen_rst_n=0 for exactly RST_HOLD cycles, echo_idx=0, then go to RUN.
- RUN: gen_rst_n=1. An internal gen_high_q is registered. A fall is gen_high_q=1 and gen_high=0.
  - The first fall (excitation end) opens no window.
  - Each later fall increments echo_idx and sets acq_gate=1.
  - acq_gate clears on the cycle after gen_high rises.
  - If echo_idx reaches cfg_echoes on a fall, go to FINAL.
  - If cfg_echoes=0, the excitation fall goes directly to RECOVER.
- FINAL: acq_gate=1 and gen_rst_n=1 for ECHO_WIN cycles. Then set gen_rst_n=0 and acq_gate=0, and go to RECOVER.
- RECOVER: gen_rst_n=0 and the tr counter runs.
  - After max(cfg_tr,1) cycles, if scan_idx=cfg_scans−1, pulse done and go to IDLE.
  - Otherwise increment scan_idx and go to ARM.
- Watchdog: a counter clears on every gen_high edge and on RUN entry. If it reaches WD_CYCLES in RUN, set error=1 and go to IDLE without pulsing done.
- abort: next state is IDLE, gen_rst_n=0, acq_gate=0, no done; scan_idx and echo_idx hold their values. abort takes precedence over every other transition in the same cycle.
- Counters are unsigned and compared for equality; none wraps within legal configurations.

## Timing
- Reset values: gen_rst_n=0, gen_delay=0, acq_gate=0, scan_idx=0, echo_idx=0, busy=0, done=0, error=0, state IDLE.
- All outputs are registered.
- With start accepted at cycle T:
  - busy=1 and ARM begins at T+1.
  - gen_rst_n rises at T+1+RST_HOLD.
  - gen_delay is valid from T+1.
- For a fall detected at cycle E (gen_high=0, gen_high_q=1), echo_idx and acq_gate update at E+1.
- After a rise of gen_high at cycle R, acq_gate=0 at R+1.
- FINAL lasts exactly ECHO_WIN cycles. gen_rst_n=0 on the first RECOVER cycle.
- done is high for exactly one cycle, concurrent with the first IDLE cycle; busy=0 in that same cycle.
- A start arriving in the same cycle as done's IDLE entry is not accepted. A start on the following cycle is accepted.
- cfg_* changes while busy have no effect.

## Test plan
Generator model or instance: TAU=4, TAU_LOW=10, TWO_TAU=8, TWO_TAU_LOW=20; sequencer ECHO_WIN=15, RST_HOLD=4.
- Single scan, cfg_echoes=2, cfg_delay=3, cfg_tr=10 -> gen_rst_n low for 4 cycles; two acq_gate windows, the first 20 cycles long and the second 15 cycles long (FINAL); echo_idx ends at 2; done pulses once; exactly 3 generator high periods observed.
- cfg_scans=3 -> scan_idx steps 0,1,2; gen_rst_n is low ≥ RECOVER+ARM between trains; exactly 3 done-free train repeats and 1 done.
- cfg_echoes=0 -> only the excitation pulse occurs; acq_gate is never asserted; done follows after cfg_tr.
- abort asserted mid-FINAL -> IDLE next cycle, gen_rst_n=0, acq_gate=0, no done; a new start then runs normally.
- gen_high held at 0 in RUN with WD_CYCLES=64 -> error=1 after 64 cycles, IDLE, no done; the next start clears error.
- start with cfg_scans=0 -> busy remains 0; start pulses while busy -> ignored, and the latched cfg is unchanged.
